// File: rtl/down_counter.sv
// Loadable down counter with one-shot / auto-reload modes and a registered terminal-count tick.
// Optional prescaler on the decrement path is compiled in with `define DOWN_COUNTER_PRESCALE_EN.
module down_counter #(
    parameter int COUNTER_BIT_NUMBER = 8,
    parameter int PRESCALE_VALUE     = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          load,
    input  logic [COUNTER_BIT_NUMBER-1:0] load_value,
    input  logic                          ctrl_dec,
    input  logic                          auto_reload,
    output logic [COUNTER_BIT_NUMBER-1:0] count,
    output logic                          busy,
    output logic                          tick
);

    localparam logic [COUNTER_BIT_NUMBER-1:0] ONE = COUNTER_BIT_NUMBER'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [COUNTER_BIT_NUMBER-1:0] count_q, count_d;
    logic [COUNTER_BIT_NUMBER-1:0] reload_q, reload_d;
    logic                          tick_q, tick_d;
    logic                          step_s;

`ifdef DOWN_COUNTER_PRESCALE_EN
    localparam int PW = (PRESCALE_VALUE > 1) ? $clog2(PRESCALE_VALUE) : 1;

    logic [PW-1:0] presc_q, presc_d;

    // Prescaler next state: count qualifying ctrl_dec cycles, restart on load and at each step
    always_comb begin
        presc_d = presc_q;
        step_s  = 1'b0;
        if (load) begin
            presc_d = '0;
        end else if ((state_q == RUN) && ctrl_dec) begin
            if (presc_q == PW'(PRESCALE_VALUE - 1)) begin
                step_s  = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // Prescaler register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    logic unused_prescale_s;

    assign unused_prescale_s = ^PRESCALE_VALUE;
    assign step_s            = (state_q == RUN) && ctrl_dec;
`endif

    // Next-state logic: load wins over stepping; the 1->0 step either reloads or parks in IDLE
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tick_d   = 1'b0;
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = (load_value != '0) ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (step_s) begin
                        if (count_q == ONE) begin
                            tick_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = IDLE;
                            end
                        end else if (count_q != '0) begin
                            count_d = count_q - ONE;
                        end else begin
                            count_d = count_q;
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, count, reload and tick registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tick_q   <= tick_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign tick  = tick_q;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: expected (count, busy, tick) pushed per driven cycle,
// observed values queued after each edge and compared in each scenario task.
module tb_down_counter;

    logic       clk;
    logic       reset_n;
    logic       load;
    logic [7:0] load_value;
    logic       ctrl_dec;
    logic       auto_reload;
    logic [7:0] count;
    logic       busy;
    logic       tick;

    typedef struct packed {
        logic [7:0] c;
        logic       b;
        logic       t;
    } sample_t;

    sample_t exp_q[$];
    sample_t obs_q[$];
    int      errors = 0;
    int      checks = 0;

    down_counter #(
        .COUNTER_BIT_NUMBER(8),
        .PRESCALE_VALUE    (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .load_value (load_value),
        .ctrl_dec   (ctrl_dec),
        .auto_reload(auto_reload),
        .count      (count),
        .busy       (busy),
        .tick       (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, record the expectation, clock, then record the observation
    task automatic apply(input logic ld, input logic [7:0] lv, input logic dec, input logic ar,
                         input logic [7:0] ec, input logic eb, input logic et);
        load        = ld;
        load_value  = lv;
        ctrl_dec    = dec;
        auto_reload = ar;
        exp_q.push_back(sample_t'({ec, eb, et}));
        @(posedge clk);
        #1;
        obs_q.push_back(sample_t'({count, busy, tick}));
    endtask

    task automatic test_reset;
        sample_t e, o;
        reset_n = 1'b0;
        #2;
        exp_q.push_back(sample_t'({8'd0, 1'b0, 1'b0}));
        obs_q.push_back(sample_t'({count, busy, tick}));
        apply(1'b1, 8'd9, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        apply(1'b1, 8'd9, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        apply(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got count=%0d busy=%b tick=%b, want count=%0d busy=%b tick=%b",
                         i, o.c, o.b, o.t, e.c, e.b, e.t);
            end
        end
    endtask

    task automatic test_oneshot;
        sample_t e, o;
        apply(1'b1, 8'd3, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0);
        apply(1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0);
        apply(1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
        apply(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++)
            apply(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL oneshot[%0d]: got count=%0d busy=%b tick=%b, want count=%0d busy=%b tick=%b",
                         i, o.c, o.b, o.t, e.c, e.b, e.t);
            end
        end
    endtask

    task automatic test_auto_reload;
        sample_t e, o;
        int      ticks;
        ticks = 0;
        apply(1'b1, 8'd2, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++)
            apply(1'b0, 8'd0, 1'b1, 1'b1, (k % 2 == 0) ? 8'd1 : 8'd2, 1'b1, (k % 2 == 1));
        apply(1'b0, 8'd0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0);
        // period-1 reload ticks on every stepped cycle
        apply(1'b1, 8'd1, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            apply(1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 1'b1, 1'b1);
        apply(1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (i >= 1 && i <= 8 && o.t === 1'b1) ticks++;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL autoreload[%0d]: got count=%0d busy=%b tick=%b, want count=%0d busy=%b tick=%b",
                         i, o.c, o.b, o.t, e.c, e.b, e.t);
            end
        end
        checks++;
        if (ticks !== 4) begin
            errors++;
            $display("FAIL autoreload_tick_count: got %0d, want 4", ticks);
        end
    endtask

    task automatic test_load_priority;
        sample_t e, o;
        apply(1'b1, 8'd5, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0);
        apply(1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 1'b1, 1'b0);
        apply(1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0);
        apply(1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0);
        apply(1'b1, 8'd7, 1'b1, 1'b0, 8'd7, 1'b1, 1'b0);
        apply(1'b0, 8'd0, 1'b0, 1'b0, 8'd7, 1'b1, 1'b0);
        // load on the would-be zero crossing cancels the tick
        apply(1'b1, 8'd1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
        apply(1'b1, 8'd6, 1'b1, 1'b0, 8'd6, 1'b1, 1'b0);
        apply(1'b0, 8'd0, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0);
        apply(1'b1, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL load_priority[%0d]: got count=%0d busy=%b tick=%b, want count=%0d busy=%b tick=%b",
                         i, o.c, o.b, o.t, e.c, e.b, e.t);
            end
        end
    endtask

    task automatic test_async_reset;
        sample_t e, o;
        apply(1'b1, 8'd4, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0);
        apply(1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0);
        apply(1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.push_back(sample_t'({8'd0, 1'b0, 1'b0}));
        obs_q.push_back(sample_t'({count, busy, tick}));
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++)
            apply(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL async_reset[%0d]: got count=%0d busy=%b tick=%b, want count=%0d busy=%b tick=%b",
                         i, o.c, o.b, o.t, e.c, e.b, e.t);
            end
        end
    endtask

    task automatic test_zero_load;
        sample_t e, o;
        apply(1'b1, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
        apply(1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
        apply(1'b1, 8'd3, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0);
        apply(1'b1, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        apply(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        apply(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL zero_load[%0d]: got count=%0d busy=%b tick=%b, want count=%0d busy=%b tick=%b",
                         i, o.c, o.b, o.t, e.c, e.b, e.t);
            end
        end
    endtask

`ifdef DOWN_COUNTER_PRESCALE_EN
    task automatic test_prescale;
        sample_t e, o;
        apply(1'b1, 8'd2, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++)
            apply(1'b0, 8'd0, 1'b1, 1'b0, (k < 4) ? 8'd2 : ((k < 8) ? 8'd1 : 8'd0),
                  (k < 8), (k == 8));
        apply(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL prescale[%0d]: got count=%0d busy=%b tick=%b, want count=%0d busy=%b tick=%b",
                         i, o.c, o.b, o.t, e.c, e.b, e.t);
            end
        end
    endtask
`endif

    initial begin
        reset_n     = 1'b0;
        load        = 1'b0;
        load_value  = 8'd0;
        ctrl_dec    = 1'b0;
        auto_reload = 1'b0;
        test_reset();
        test_oneshot();
        test_auto_reload();
        test_load_priority();
        test_async_reset();
        test_zero_load();
`ifdef DOWN_COUNTER_PRESCALE_EN
        test_prescale();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
